// File: rtl/pool_requant_buffer.sv
// Requantizes 2x2 average-pool window sums (divide by 4, round, saturate) and
// buffers them in a first-word-fall-through FIFO with end-of-frame tagging.
module pool_requant_buffer #(
  parameter int IN_WIDTH   = 6,
  parameter int OUT_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int POOL_W     = 16,
  parameter int POOL_H     = 16,
  parameter int ROUND      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam int RW    = (POOL_H > 1) ? $clog2(POOL_H) : 1;
  localparam int SW    = IN_WIDTH + 1;

  localparam logic [SW-1:0]    ROUND_ADD = (ROUND != 0) ? SW'(2) : '0;
  localparam logic [SW-1:0]    Q_MAX     = SW'((1 << OUT_WIDTH) - 1);
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0]    COL_LAST  = CW'(POOL_W - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(POOL_H - 1);

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] q;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;

  logic [SW-1:0] sum, shifted;
  logic          at_last, full, push, pop, drop;
  entry_t        wr_entry, head;

  always_comb begin
    sum        = {1'b0, din} + ROUND_ADD;
    shifted    = sum >> 2;
    at_last    = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    wr_entry.q    = (shifted > Q_MAX) ? '1 : shifted[OUT_WIDTH-1:0];
    wr_entry.last = at_last;

    full       = (count == DEPTH);
    dout_valid = (count != '0);
    pop        = dout_valid && dout_ready;
    // A full FIFO still accepts a pulse when the head leaves in the same cycle.
    push       = din_valid && (!full || pop);
    drop       = din_valid && full && !pop;
    din_ready  = (count <= READY_MAX);

    head       = mem[rd_ptr];
    dout       = dout_valid ? head.q : '0;
    dout_last  = dout_valid && head.last;
  end

  // NOTE: the storage array has no reset; stale words are unreachable because
  // the pointers and count are reset, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      // Frame position tracks every pulse, dropped or not, to stay aligned.
      if (din_valid) begin
        if (at_last) begin
          col_cnt <= '0;
          row_cnt <= '0;
        end else if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_requant_buffer.sv
// Directed bench for pool_requant_buffer: rounding, backpressure, overflow,
// full-with-pop, frame tagging and mid-frame reset.
module tb_pool_requant_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] din = '0;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b0;

  // Default instance: ROUND=1, 16x16 frame
  logic       rdy_a, val_a, last_a, ovf_a;
  logic [3:0] dout_a;
  // ROUND=0 instance
  logic       rdy_b, val_b, last_b, ovf_b;
  logic [3:0] dout_b;
  // 2x2 frame instance
  logic       rdy_f, val_f, last_f, ovf_f;
  logic [3:0] dout_f;

  int total = 0;
  int bad   = 0;

  pool_requant_buffer dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .dout(dout_a), .dout_valid(val_a), .dout_ready(dout_ready),
    .dout_last(last_a), .overflow(ovf_a)
  );

  pool_requant_buffer #(.ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .dout(dout_b), .dout_valid(val_b), .dout_ready(dout_ready),
    .dout_last(last_b), .overflow(ovf_b)
  );

  pool_requant_buffer #(.POOL_W(2), .POOL_H(2)) dut_f (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_f),
    .dout(dout_f), .dout_valid(val_f), .dout_ready(dout_ready),
    .dout_last(last_f), .overflow(ovf_f)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Push 8 entries into an empty FIFO with dout_ready low; entry i holds q=i+1.
  task automatic fill8();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 6'(4 * (i + 1)); din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({val_a, dout_a, last_a, rdy_a, ovf_a} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%0d l=%b r=%b o=%b want v=0 d=0 l=0 r=1 o=0",
               val_a, dout_a, last_a, rdy_a, ovf_a);
    end
  endtask

  task automatic test_rounding();
    logic [5:0] dins [7];
    logic [3:0] exp1 [7];
    logic [3:0] exp0 [7];
    dins = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd60, 6'd63};
    exp1 = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd15, 4'd15};
    exp0 = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd15};
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = dins[i]; din_valid = 1'b1;
      step();
      total++;
      if ({val_a, dout_a} !== {1'b1, exp1[i]}) begin
        bad++;
        $display("FAIL round1 din=%0d: got v=%b d=%0d want v=1 d=%0d", dins[i], val_a, dout_a, exp1[i]);
      end
      total++;
      if ({val_b, dout_b} !== {1'b1, exp0[i]}) begin
        bad++;
        $display("FAIL round0 din=%0d: got v=%b d=%0d want v=1 d=%0d", dins[i], val_b, dout_b, exp0[i]);
      end
    end
    din_valid = 1'b0;
    step();
    total++;
    if ({val_a, dout_a} !== {1'b0, 4'd0}) begin
      bad++;
      $display("FAIL round_drain_empty: got v=%b d=%0d want v=0 d=0", val_a, dout_a);
    end
  endtask

  task automatic test_backpressure_fill();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 6'(4 * (i + 1)); din_valid = 1'b1;
      step();
      // count is now i+1; ready only while count <= 6
      total++;
      if ({val_a, dout_a, rdy_a} !== {1'b1, 4'd1, (i + 1 <= 6)}) begin
        bad++;
        $display("FAIL fill_%0d: got v=%b d=%0d r=%b want v=1 d=1 r=%b",
                 i + 1, val_a, dout_a, rdy_a, (i + 1 <= 6));
      end
    end
    din_valid = 1'b0;
    step();
    total++;
    if ({val_a, dout_a, rdy_a, ovf_a} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fill_hold: got v=%b d=%0d r=%b o=%b want v=1 d=1 r=0 o=0", val_a, dout_a, rdy_a, ovf_a);
    end
    dout_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      total++;
      if ({val_a, dout_a, rdy_a} !== {1'b1, 4'(j + 1), (8 - j <= 6)}) begin
        bad++;
        $display("FAIL drain_%0d: got v=%b d=%0d r=%b want v=1 d=%0d r=%b",
                 j, val_a, dout_a, rdy_a, j + 1, (8 - j <= 6));
      end
      step();
    end
    total++;
    if ({val_a, dout_a, rdy_a} !== {1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL drain_empty: got v=%b d=%0d r=%b want v=0 d=0 r=1", val_a, dout_a, rdy_a);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill8();
    total++;
    if (ovf_a !== 1'b0) begin
      bad++;
      $display("FAIL ovf_before: got %b want 0", ovf_a);
    end
    din = 6'd36; din_valid = 1'b1;  // q=9, must be dropped
    step();
    din_valid = 1'b0;
    total++;
    if ({ovf_a, val_a, dout_a} !== {1'b1, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL ovf_set: got o=%b v=%b d=%0d want o=1 v=1 d=1", ovf_a, val_a, dout_a);
    end
    dout_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      total++;
      if ({val_a, dout_a} !== {1'b1, 4'(j + 1)}) begin
        bad++;
        $display("FAIL ovf_drain_%0d: got v=%b d=%0d want v=1 d=%0d", j, val_a, dout_a, j + 1);
      end
      step();
    end
    total++;
    if ({val_a, ovf_a} !== {1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ovf_sticky: got v=%b o=%b want v=0 o=1", val_a, ovf_a);
    end
    do_reset();
    total++;
    if (ovf_a !== 1'b0) begin
      bad++;
      $display("FAIL ovf_cleared: got %b want 0", ovf_a);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    fill8();
    dout_ready = 1'b1; din = 6'd36; din_valid = 1'b1;  // q=9 pushed while head pops
    step();
    din_valid = 1'b0;
    total++;
    if ({val_a, dout_a, rdy_a, ovf_a} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fullpop: got v=%b d=%0d r=%b o=%b want v=1 d=2 r=0 o=0", val_a, dout_a, rdy_a, ovf_a);
    end
    for (int j = 0; j < 8; j++) begin
      total++;
      if ({val_a, dout_a} !== {1'b1, 4'(j + 2)}) begin
        bad++;
        $display("FAIL fullpop_drain_%0d: got v=%b d=%0d want v=1 d=%0d", j, val_a, dout_a, j + 2);
      end
      step();
    end
    total++;
    if ({val_a, ovf_a} !== {1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fullpop_end: got v=%b o=%b want v=0 o=0", val_a, ovf_a);
    end
  endtask

  task automatic test_frame_tag();
    do_reset();
    dout_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      din = 6'(4 * (k + 1)); din_valid = 1'b1;
      step();
      total++;
      if ({val_f, dout_f, last_f} !== {1'b1, 4'(k + 1), ((k + 1) % 4 == 0)}) begin
        bad++;
        $display("FAIL frame_%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                 k + 1, val_f, dout_f, last_f, k + 1, ((k + 1) % 4 == 0));
      end
    end
    din_valid = 1'b0;
    step();
    total++;
    if ({val_f, last_f} !== {1'b0, 1'b0}) begin
      bad++;
      $display("FAIL frame_end: got v=%b l=%b want v=0 l=0", val_f, last_f);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 6'(4 * (i + 1)); din_valid = 1'b1;
      step();
    end
    // Reset with a pulse present; the pulse must be ignored.
    rst = 1'b1; din = 6'd40; din_valid = 1'b1;
    step();
    rst = 1'b0; din_valid = 1'b0;
    total++;
    if ({val_f, dout_f, last_f, rdy_f, ovf_f} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_state: got v=%b d=%0d l=%b r=%b o=%b want v=0 d=0 l=0 r=1 o=0",
               val_f, dout_f, last_f, rdy_f, ovf_f);
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 6'(4 * (k + 1)); din_valid = 1'b1;
      step();
      total++;
      if ({val_f, dout_f, last_f} !== {1'b1, 4'(k + 1), (k == 3)}) begin
        bad++;
        $display("FAIL rstmid_tag_%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                 k + 1, val_f, dout_f, last_f, k + 1, (k == 3));
      end
    end
    din_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_backpressure_fill();
    test_overflow();
    test_full_pop();
    test_frame_tag();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
